// File: rtl/variable_table_pkg.sv
// variable_table_pkg
// Shared definitions for the variable table sequencer: the FSM state
// encoding and the mapping from state to the tables_stable indication.
package variable_table_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_READY     = 3'd2,
        ST_FLIP_RD   = 3'd3,
        ST_FLIP_WAIT = 3'd4,
        ST_FLIP_WR   = 3'd5
    } state_t;

    localparam logic [15:0] FLIP_COUNT_MAX = 16'hFFFF;

    // Port-A readers may trust the tables only while no write is in flight.
    function automatic logic state_is_stable(input state_t s);
        return (s == ST_READY) || (s == ST_FLIP_RD) || (s == ST_FLIP_WAIT);
    endfunction

endpackage

// File: rtl/variable_table_port_fanout.sv
// variable_table_port_fanout
// Replicates one set of port-B controls to CLUSTER_SIZE identical tables.
// Ports:
//   i_en, i_en_first_only : enable all tables, or only table 0 when first_only
//   i_we, i_din, i_addr   : shared write enable / data / address
//   o_en_b, o_we_b, o_din_b : one bit per table, qualified by that table's enable
//   o_addr_b              : table i address at slice i
module variable_table_port_fanout
    import variable_table_pkg::*;
#(
    parameter int ADDR_W       = 11,
    parameter int CLUSTER_SIZE = 40
) (
    input  logic                           i_en,
    input  logic                           i_en_first_only,
    input  logic                           i_we,
    input  logic                           i_din,
    input  logic [ADDR_W-1:0]              i_addr,
    output logic [CLUSTER_SIZE-1:0]        o_en_b,
    output logic [CLUSTER_SIZE-1:0]        o_we_b,
    output logic [CLUSTER_SIZE-1:0]        o_din_b,
    output logic [ADDR_W*CLUSTER_SIZE-1:0] o_addr_b
);

    for (genvar g = 0; g < CLUSTER_SIZE; g++) begin : g_slice
        logic w_en;
        if (g == 0) begin : g_first
            assign w_en = i_en;
        end else begin : g_rest
            assign w_en = i_en & ~i_en_first_only;
        end
        // we/din are gated so idle tables see all-zero controls
        assign o_en_b[g]                   = w_en;
        assign o_we_b[g]                   = w_en & i_we;
        assign o_din_b[g]                  = w_en & i_din;
        assign o_addr_b[g*ADDR_W +: ADDR_W] = i_addr;
    end

endmodule

// File: rtl/variable_table_sequencer.sv
// variable_table_sequencer
// Initialises a cluster of replicated variable tables from a bit stream and
// then services single-variable flip requests (read table 0, write the
// inverted value to every table).
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   init_start                         : start (re)initialisation
//   init_valid/init_bit/init_ready     : initial-value stream, one variable per beat
//   init_done                          : pulse after the last variable is written
//   flip_valid/flip_addr/flip_ready    : flip request handshake
//   flip_done/flip_value/flip_error    : completion pulse, new value, out-of-range pulse
//   tables_stable                      : port-A reads are trustworthy
//   flip_count                         : saturating completed-flip count since init
//   en_b/we_b/din_b/addr_b             : port-B controls, one slice per table
//   dout_b0                            : table 0 port-B read data, one-cycle latency
//
// state      | meaning
// -----------+---------------------------------------------------
// IDLE       | after reset, tables not initialised
// INIT       | accepting the initial-value stream
// READY      | tables valid, accepting flip requests
// FLIP_RD    | reading captured address from table 0
// FLIP_WAIT  | table 0 read data arriving on dout_b0
// FLIP_WR    | writing inverted value to all tables
module variable_table_sequencer
    import variable_table_pkg::*;
#(
    parameter int          LITERAL_ADDRESS_WIDTH = 11,
    parameter int          CLUSTER_SIZE          = 40,
    parameter int          NUM_VARIABLES         = 2000,  // must not exceed 2**LITERAL_ADDRESS_WIDTH
    parameter logic [15:0] FLIP_COUNT_INIT       = 16'h0000  // value loaded by init_start
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      init_start,
    input  logic                                      init_valid,
    input  logic                                      init_bit,
    output logic                                      init_ready,
    output logic                                      init_done,
    input  logic                                      flip_valid,
    input  logic [LITERAL_ADDRESS_WIDTH-1:0]          flip_addr,
    output logic                                      flip_ready,
    output logic                                      flip_done,
    output logic                                      flip_value,
    output logic                                      flip_error,
    output logic                                      tables_stable,
    output logic [15:0]                               flip_count,
    output logic [CLUSTER_SIZE-1:0]                   en_b,
    output logic [CLUSTER_SIZE-1:0]                   we_b,
    output logic [CLUSTER_SIZE-1:0]                   din_b,
    output logic [LITERAL_ADDRESS_WIDTH*CLUSTER_SIZE-1:0] addr_b,
    input  logic                                      dout_b0
);

    localparam int AW = LITERAL_ADDRESS_WIDTH;
    localparam logic [AW-1:0] LAST_ADDR    = AW'(NUM_VARIABLES - 1);
    // One extra bit so the range check also works when NUM_VARIABLES == 2**AW
    localparam logic [AW:0]   NUM_VARS_EXT = (AW+1)'(NUM_VARIABLES);

    state_t          r_state, w_next_state;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   r_flip_addr;
    logic            r_rd_bit;
    logic            r_init_done, r_flip_done, r_flip_value, r_flip_error;
    logic [15:0]     r_flip_count;

    logic            w_start, w_init_beat, w_last_beat, w_flip_acc, w_flip_oor;
    logic            w_en, w_en_first_only, w_we, w_din;
    logic [AW-1:0]   w_addr;

    assign w_start     = init_start & ((r_state == ST_IDLE) | (r_state == ST_READY));
    assign w_init_beat = (r_state == ST_INIT) & init_valid;
    assign w_last_beat = w_init_beat & (r_cnt == LAST_ADDR);
    assign w_flip_acc  = flip_valid & flip_ready;
    assign w_flip_oor  = {1'b0, flip_addr} >= NUM_VARS_EXT;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (w_start) w_next_state = ST_INIT;
            ST_INIT:      if (w_last_beat) w_next_state = ST_READY;
            ST_READY: begin
                if (w_start)                         w_next_state = ST_INIT;
                else if (w_flip_acc && !w_flip_oor)  w_next_state = ST_FLIP_RD;
            end
            ST_FLIP_RD:   w_next_state = ST_FLIP_WAIT;
            ST_FLIP_WAIT: w_next_state = ST_FLIP_WR;
            ST_FLIP_WR:   w_next_state = ST_READY;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_en            = 1'b0;
        w_en_first_only = 1'b0;
        w_we            = 1'b0;
        w_din           = 1'b0;
        w_addr          = '0;
        init_ready      = (r_state == ST_INIT);
        // init_start wins over a simultaneous flip request
        flip_ready      = (r_state == ST_READY) & ~init_start;
        tables_stable   = state_is_stable(r_state);
        case (r_state)
            ST_INIT: begin
                if (init_valid) begin
                    w_en   = 1'b1;
                    w_we   = 1'b1;
                    w_din  = init_bit;
                    w_addr = r_cnt;
                end
            end
            ST_FLIP_RD: begin
                w_en            = 1'b1;
                w_en_first_only = 1'b1;
                w_addr          = r_flip_addr;
            end
            ST_FLIP_WR: begin
                w_en   = 1'b1;
                w_we   = 1'b1;
                w_din  = ~r_rd_bit;
                w_addr = r_flip_addr;
            end
            default: ;
        endcase
    end

    // Datapath: counters, captured request, read data and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_flip_addr  <= '0;
            r_rd_bit     <= 1'b0;
            r_init_done  <= 1'b0;
            r_flip_done  <= 1'b0;
            r_flip_value <= 1'b0;
            r_flip_error <= 1'b0;
            r_flip_count <= '0;
        end else begin
            r_init_done  <= w_last_beat;
            r_flip_error <= w_flip_acc & w_flip_oor;
            r_flip_done  <= (r_state == ST_FLIP_WR);
            r_flip_value <= (r_state == ST_FLIP_WR) & ~r_rd_bit;
            if (w_start) begin
                r_cnt        <= '0;
                r_flip_count <= FLIP_COUNT_INIT;
            end else if (w_init_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_flip_acc)
                r_flip_addr <= flip_addr;
            if (r_state == ST_FLIP_WAIT)
                r_rd_bit <= dout_b0;
            if ((r_state == ST_FLIP_WR) && (r_flip_count != FLIP_COUNT_MAX))
                r_flip_count <= r_flip_count + 16'd1;
        end
    end

    assign init_done  = r_init_done;
    assign flip_done  = r_flip_done;
    assign flip_value = r_flip_value;
    assign flip_error = r_flip_error;
    assign flip_count = r_flip_count;

    variable_table_port_fanout #(
        .ADDR_W       (AW),
        .CLUSTER_SIZE (CLUSTER_SIZE)
    ) u_fanout (
        .i_en            (w_en),
        .i_en_first_only (w_en_first_only),
        .i_we            (w_we),
        .i_din           (w_din),
        .i_addr          (w_addr),
        .o_en_b          (en_b),
        .o_we_b          (we_b),
        .o_din_b         (din_b),
        .o_addr_b        (addr_b)
    );

endmodule

// File: tb/tb_variable_table_sequencer.sv
module tb_variable_table_sequencer;

    localparam int W     = 11;
    localparam int CS    = 40;
    localparam int NV    = 2000;
    localparam int DEPTH = 2**W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_start = 1'b0, init_valid = 1'b0, init_bit = 1'b0, flip_valid = 1'b0;
    logic [W-1:0] flip_addr = '0;

    logic init_ready, init_done, flip_ready, flip_done, flip_value, flip_error, tables_stable;
    logic [15:0] flip_count;
    logic [CS-1:0] en_b, we_b, din_b;
    logic [W*CS-1:0] addr_b;
    logic dout_b0;

    logic init_ready_s, init_done_s, flip_ready_s, flip_done_s, flip_value_s, flip_error_s, tables_stable_s;
    logic [15:0] flip_count_s;
    logic [CS-1:0] en_b_s, we_b_s, din_b_s;
    logic [W*CS-1:0] addr_b_s;
    logic dout_b0_s;

    always #5 clk = ~clk;

    variable_table_sequencer #(.LITERAL_ADDRESS_WIDTH(W), .CLUSTER_SIZE(CS), .NUM_VARIABLES(NV)) dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_valid(init_valid), .init_bit(init_bit),
        .init_ready(init_ready), .init_done(init_done), .flip_valid(flip_valid), .flip_addr(flip_addr),
        .flip_ready(flip_ready), .flip_done(flip_done), .flip_value(flip_value), .flip_error(flip_error),
        .tables_stable(tables_stable), .flip_count(flip_count), .en_b(en_b), .we_b(we_b), .din_b(din_b),
        .addr_b(addr_b), .dout_b0(dout_b0));

    // Second instance with a preloaded flip count, driven by the same stimulus
    variable_table_sequencer #(.LITERAL_ADDRESS_WIDTH(W), .CLUSTER_SIZE(CS), .NUM_VARIABLES(NV),
                               .FLIP_COUNT_INIT(16'hFFFE)) dut_sat (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_valid(init_valid), .init_bit(init_bit),
        .init_ready(init_ready_s), .init_done(init_done_s), .flip_valid(flip_valid), .flip_addr(flip_addr),
        .flip_ready(flip_ready_s), .flip_done(flip_done_s), .flip_value(flip_value_s), .flip_error(flip_error_s),
        .tables_stable(tables_stable_s), .flip_count(flip_count_s), .en_b(en_b_s), .we_b(we_b_s), .din_b(din_b_s),
        .addr_b(addr_b_s), .dout_b0(dout_b0_s));

    // Table environment: CS tables for the main instance, table 0 for the second
    bit   mem   [CS][DEPTH];
    bit   mem_s [DEPTH];
    logic rd0 = 1'b0, rd0_s = 1'b0;
    assign dout_b0   = rd0;
    assign dout_b0_s = rd0_s;

    int en_events = 0, wr_events = 0, addr_viol = 0, idle_viol = 0, sat_diff = 0;

    function automatic bit slices_differ(input logic [W*CS-1:0] v);
        for (int t = 1; t < CS; t++)
            if (v[t*W +: W] !== v[W-1:0]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        for (int t = 0; t < CS; t++)
            if (en_b[t] && we_b[t]) mem[t][addr_b[t*W +: W]] <= din_b[t];
        if (en_b[0] && !we_b[0]) rd0 <= mem[0][addr_b[W-1:0]];
        if (en_b_s[0] && we_b_s[0]) mem_s[addr_b_s[W-1:0]] <= din_b_s[0];
        if (en_b_s[0] && !we_b_s[0]) rd0_s <= mem_s[addr_b_s[W-1:0]];
        if (|en_b) en_events <= en_events + 1;
        if (|(en_b & we_b)) wr_events <= wr_events + 1;
        if ((|en_b) && slices_differ(addr_b)) addr_viol <= addr_viol + 1;
        if (|((we_b | din_b) & ~en_b)) idle_viol <= idle_viol + 1;
        if ({en_b, we_b, din_b, addr_b, init_ready, init_done, flip_ready, flip_done, flip_value, flip_error, tables_stable}
            !== {en_b_s, we_b_s, din_b_s, addr_b_s, init_ready_s, init_done_s, flip_ready_s, flip_done_s,
                 flip_value_s, flip_error_s, tables_stable_s})
            sat_diff <= sat_diff + 1;
    end

    // Reference model: expected variable values and expected counters
    bit          ref_vals [NV];
    logic [15:0] ref_count, ref_count_s;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_en_we_din"}, {en_b, we_b, din_b}, '0);
        check({tag, "_addr_b"}, addr_b, '0);
        check({tag, "_ready_stable"}, {init_ready, flip_ready, tables_stable}, '0);
        check({tag, "_pulses"}, {init_done, flip_done, flip_value, flip_error}, '0);
        check({tag, "_flip_count"}, flip_count, '0);
    endtask

    task automatic check_tables(input string tag);
        int bad;
        for (int t = 0; t < CS; t++) begin
            bad = 0;
            for (int a = 0; a < NV; a++)
                if (mem[t][a] != ref_vals[a]) bad++;
            check({tag, "_table"}, bad, 0);
        end
        bad = 0;
        for (int a = 0; a < NV; a++)
            if (mem_s[a] != ref_vals[a]) bad++;
        check({tag, "_table_sat"}, bad, 0);
    endtask

    // mode 0: odd addresses 1, even 0; mode 1: random bits. abort_at >= 0 resets at that beat.
    task automatic run_init(input int mode, input int abort_at);
        logic         b;
        logic [W-1:0] a;
        int           wr0;
        init_start = 1'b1;
        #1 check("start_init_ready_low", init_ready, 1'b0);
        step();
        init_start = 1'b0;
        ref_count   = 16'h0000;
        ref_count_s = 16'hFFFE;
        for (int i = 0; i < NV; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                init_valid = 1'b0;
                #1 check("init_gap_en", en_b, '0);
                step();
            end
            a = W'(i);
            b = (mode == 0) ? a[0] : 1'($urandom_range(0, 1));
            if (i == abort_at) b = ~ref_vals[i];
            init_valid = 1'b1;
            init_bit   = b;
            #1;
            check("init_ready", init_ready, 1'b1);
            check("init_en_we", {en_b, we_b}, {2*CS{1'b1}});
            check("init_din", din_b, {CS{b}});
            check("init_addr", addr_b, {CS{a}});
            check("init_stable_done", {tables_stable, init_done}, 2'b00);
            if (i == abort_at) begin
                wr0 = wr_events;
                #1 rst_n = 1'b0;
                #1 check_all_zero("abort");
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                check("abort_no_write", wr_events, wr0);
                init_valid = 1'b0;
                rst_n = 1'b1;
                #1 check("abort_idle", {init_ready, flip_ready, tables_stable, flip_count}, '0);
                ref_count   = 16'h0000;
                ref_count_s = 16'h0000;
                return;
            end
            ref_vals[i] = b;
            step();
        end
        init_valid = 1'b0;
        #1;
        check("init_done_pulse", init_done, 1'b1);
        check("init_to_ready", {flip_ready, tables_stable, init_ready}, 3'b110);
        check("init_flip_count", flip_count, ref_count);
        check("init_flip_count_sat", flip_count_s, ref_count_s);
        step();
        #1 check("init_done_one_cycle", init_done, 1'b0);
    endtask

    task automatic do_flip(input logic [W-1:0] a, input bit disturb);
        logic exp_v;
        int   en0;
        flip_valid = 1'b1;
        flip_addr  = a;
        #1 check("flip_ready_in_ready", flip_ready, 1'b1);
        step();
        flip_valid = 1'b0;
        flip_addr  = W'($urandom);
        en0 = en_events;
        if (int'(a) >= NV) begin
            #1;
            check("oor_error_pulse", {flip_error, flip_done}, 2'b10);
            check("oor_no_en", en_b, '0);
            check("oor_stays_ready", flip_ready, 1'b1);
            step();
            #1;
            check("oor_error_one_cycle", flip_error, 1'b0);
            check("oor_no_access", en_events, en0);
            check("oor_count_same", flip_count, ref_count);
            return;
        end
        exp_v = ~ref_vals[a];
        ref_vals[a] = exp_v;
        #1;
        check("rd_en", {en_b, we_b}, {{(2*CS-1){1'b0}}, 1'b1} << CS);
        check("rd_addr", addr_b, {CS{a}});
        check("rd_stable_ready_done", {tables_stable, flip_ready, flip_done}, 3'b100);
        step();
        #1 check("wait_idle", {en_b, tables_stable, flip_done}, {{CS{1'b0}}, 2'b10});
        step();
        #1;
        check("wr_en_we", {en_b, we_b}, {2*CS{1'b1}});
        check("wr_din", din_b, {CS{exp_v}});
        check("wr_addr", addr_b, {CS{a}});
        check("wr_stable_ready_done", {tables_stable, flip_ready, flip_done}, 3'b000);
        if (disturb) begin
            init_start = 1'b1;
            flip_valid = 1'b1;
            flip_addr  = W'($urandom_range(0, NV - 1));
            #1 check("wr_holdoff", flip_ready, 1'b0);
        end
        step();
        init_start = 1'b0;
        flip_valid = 1'b0;
        ref_count   = sat_inc(ref_count);
        ref_count_s = sat_inc(ref_count_s);
        #1;
        check("done_pulse_value", {flip_done, flip_value}, {1'b1, exp_v});
        check("done_flip_count", flip_count, ref_count);
        check("done_flip_count_sat", flip_count_s, ref_count_s);
        check("done_back_ready", {init_ready, tables_stable, flip_ready}, 3'b011);
        step();
        #1 check("after_done_quiet", {flip_done, en_b}, '0);
    endtask

    initial begin
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        #1 check("idle_after_reset", {init_ready, flip_ready, tables_stable}, 3'b000);

        run_init(0, -1);
        check_tables("init_alt");

        do_flip(W'(5), 1'b0);
        check("flip5_value_zero", mem[0][5], 1'b0);
        check("flip5_count_one", flip_count, 16'd1);
        do_flip(W'(2000), 1'b0);
        check("oor2000_count_one", flip_count, 16'd1);

        for (int k = 0; k < 10; k++) begin
            if (k % 4 == 3) do_flip(W'($urandom_range(NV, DEPTH - 1)), 1'b0);
            else            do_flip(W'($urandom_range(0, NV - 1)), k == 5);
            repeat ($urandom_range(0, 3)) step();
        end
        check_tables("after_flips");

        run_init(1, 700);
        check_tables("after_abort");

        run_init(1, -1);
        for (int k = 0; k < 3; k++) do_flip(W'($urandom_range(0, NV - 1)), 1'b0);
        check("sat_count_ffff", flip_count_s, 16'hFFFF);
        check("count_three", flip_count, 16'd3);
        check_tables("final");

        step();
        check("addr_slices_equal", addr_viol, 0);
        check("idle_controls_zero", idle_viol, 0);
        check("instances_agree", sat_diff, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
